// File: rtl/gen_mod_pkg.sv
// Shared definitions for the harmonic modulation generator: FSM encoding and
// the widths agreed between the DDS, the register bank and the sweep controller.
package gen_mod_pkg;

    localparam int HP_W_DEF = 14;
    localparam int PH_W_DEF = 12;
    localparam int DW_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        DWELL = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/gen_mod_dwell_cnt.sv
// Counts DDS period boundaries and emits a registered one-cycle expire pulse
// on the trig that completes a dwell of `target` periods.
module gen_mod_dwell_cnt #(
    parameter int DW_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            trig,
    input  logic [DW_W-1:0] target,
    output logic            expire
);

    logic [DW_W-1:0] cnt;

    // target is never 0 here: the controller latches max(dwell, 1)
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (trig) begin
                if (cnt >= target - DW_W'(1)) begin
                    cnt    <= '0;
                    expire <= 1'b1;
                end else begin
                    cnt <= cnt + DW_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gen_mod_sweep_ctrl.sv
// Drives the DDS increment/offset: boundary-aligned static updates from the
// register bank, or a linear hp sweep with per-step dwell, one-shot or looping.
module gen_mod_sweep_ctrl
    import gen_mod_pkg::*;
#(
    parameter int HP_W = HP_W_DEF,
    parameter int PH_W = PH_W_DEF,
    parameter int DW_W = DW_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [HP_W-1:0] cfg_hp,
    input  logic [PH_W-1:0] cfg_phase,
    input  logic            cfg_upd,
    input  logic            sw_start,
    input  logic            sw_abort,
    input  logic            sw_loop,
    input  logic [HP_W-1:0] sw_hp_stop,
    input  logic [HP_W-1:0] sw_hp_step,
    input  logic [DW_W-1:0] sw_dwell,
    input  logic            harmonic_trig,
    output logic [HP_W-1:0] hp,
    output logic [PH_W-1:0] phase,
    output logic            dds_rst,
    output logic            busy,
    output logic            upd_pending,
    output logic            sweep_done,
    output logic [HP_W-1:0] step_idx
);

    state_t          state, state_n;
    logic [HP_W-1:0] hp_n, sh_hp, sh_hp_n, start_reg, start_n;
    logic [HP_W-1:0] stop_reg, stop_n, step_reg, step_n, idx_n;
    logic [PH_W-1:0] phase_n, sh_ph, sh_ph_n;
    logic [DW_W-1:0] dwell_reg, dwell_n;
    logic            loop_reg, loop_n, pend_n;
    logic [HP_W:0]   nxt;
    logic            expire;

    gen_mod_dwell_cnt #(.DW_W(DW_W)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != DWELL),
        .trig   (harmonic_trig && state == DWELL),
        .target (dwell_reg),
        .expire (expire)
    );

    always_comb begin
        state_n = state;
        hp_n    = hp;
        phase_n = phase;
        sh_hp_n = sh_hp;
        sh_ph_n = sh_ph;
        pend_n  = upd_pending;
        start_n = start_reg;
        stop_n  = stop_reg;
        step_n  = step_reg;
        dwell_n = dwell_reg;
        loop_n  = loop_reg;
        idx_n   = step_idx;
        // carry-out lands in the top bit so it reads as "past stop"
        nxt     = {1'b0, hp} + {1'b0, step_reg};

        case (state)
            IDLE: begin
                if (sw_start && !sw_abort) begin
                    state_n = ARM;
                    hp_n    = cfg_hp;
                    phase_n = cfg_phase;
                    start_n = cfg_hp;
                    stop_n  = sw_hp_stop;
                    step_n  = sw_hp_step;
                    dwell_n = (sw_dwell == '0) ? DW_W'(1) : sw_dwell;
                    loop_n  = sw_loop;
                    pend_n  = 1'b0;
                end else if (cfg_upd && harmonic_trig) begin
                    hp_n    = cfg_hp;
                    phase_n = cfg_phase;
                    pend_n  = 1'b0;
                end else if (cfg_upd) begin
                    sh_hp_n = cfg_hp;
                    sh_ph_n = cfg_phase;
                    pend_n  = 1'b1;
                end else if (upd_pending && (harmonic_trig || hp == '0)) begin
                    // hp==0 means the DDS is stalled and no boundary will come
                    hp_n    = sh_hp;
                    phase_n = sh_ph;
                    pend_n  = 1'b0;
                end
            end
            ARM: begin
                idx_n = '0;
                if (sw_abort)             state_n = IDLE;
                else if (start_reg == '0) state_n = DONE;
                else                      state_n = DWELL;
            end
            DWELL: begin
                if (sw_abort)    state_n = IDLE;
                else if (expire) state_n = STEP;
            end
            STEP: begin
                if (sw_abort) begin
                    state_n = IDLE;
                end else if (step_reg == '0 || nxt > {1'b0, stop_reg}) begin
                    if (loop_reg) begin
                        hp_n    = start_reg;
                        idx_n   = '0;
                        state_n = DWELL;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    hp_n    = nxt[HP_W-1:0];
                    idx_n   = step_idx + HP_W'(1);
                    state_n = DWELL;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hp          <= '0;
            phase       <= '0;
            sh_hp       <= '0;
            sh_ph       <= '0;
            upd_pending <= 1'b0;
            start_reg   <= '0;
            stop_reg    <= '0;
            step_reg    <= '0;
            dwell_reg   <= DW_W'(1);
            loop_reg    <= 1'b0;
            step_idx    <= '0;
            dds_rst     <= 1'b0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state       <= state_n;
            hp          <= hp_n;
            phase       <= phase_n;
            sh_hp       <= sh_hp_n;
            sh_ph       <= sh_ph_n;
            upd_pending <= pend_n;
            start_reg   <= start_n;
            stop_reg    <= stop_n;
            step_reg    <= step_n;
            dwell_reg   <= dwell_n;
            loop_reg    <= loop_n;
            step_idx    <= idx_n;
            dds_rst     <= (state_n == ARM);
            busy        <= (state_n != IDLE);
            sweep_done  <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_gen_mod_sweep_ctrl.sv
// Directed bench: stimulus queues expected hp/phase updates and point probes;
// a negedge monitor does every comparison.
module tb_gen_mod_sweep_ctrl;

    localparam int HP_W = 14;
    localparam int PH_W = 12;
    localparam int DW_W = 16;

    localparam int K_HP = 0, K_PH = 1, K_RST = 2, K_BUSY = 3, K_PEND = 4;
    localparam int K_DONE = 5, K_IDX = 6, K_SDCNT = 7, K_RCCNT = 8, K_QSZ = 9;

    typedef struct {
        int    kind;
        int    val;
        string name;
    } probe_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [HP_W-1:0] cfg_hp, sw_hp_stop, sw_hp_step;
    logic [PH_W-1:0] cfg_phase;
    logic            cfg_upd, sw_start, sw_abort, sw_loop, harmonic_trig;
    logic [DW_W-1:0] sw_dwell;
    logic [HP_W-1:0] hp, step_idx;
    logic [PH_W-1:0] phase;
    logic            dds_rst, busy, upd_pending, sweep_done;

    logic [HP_W+PH_W-1:0] exp_q[$];
    probe_t               pq[$];
    logic [HP_W+PH_W-1:0] prev = '0;
    logic                 mon_en = 1'b0;
    int checks = 0, errors = 0;
    int sd_cnt = 0, rc_cnt = 0, esd = 0, erc = 0;

    gen_mod_sweep_ctrl #(.HP_W(HP_W), .PH_W(PH_W), .DW_W(DW_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_hp        (cfg_hp),
        .cfg_phase     (cfg_phase),
        .cfg_upd       (cfg_upd),
        .sw_start      (sw_start),
        .sw_abort      (sw_abort),
        .sw_loop       (sw_loop),
        .sw_hp_stop    (sw_hp_stop),
        .sw_hp_step    (sw_hp_step),
        .sw_dwell      (sw_dwell),
        .harmonic_trig (harmonic_trig),
        .hp            (hp),
        .phase         (phase),
        .dds_rst       (dds_rst),
        .busy          (busy),
        .upd_pending   (upd_pending),
        .sweep_done    (sweep_done),
        .step_idx      (step_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    // Monitor: scoreboard of hp/phase updates, pulse counters, point probes
    always @(negedge clk) begin
        logic [HP_W+PH_W-1:0] cur, e;
        probe_t p;
        int act;
        if (mon_en) begin
            cur = {hp, phase};
            if (cur != prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got hp=%0d phase=%0h, none expected", hp, phase);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        errors++;
                        $display("FAIL sb_update: got hp=%0d phase=%0h, want hp=%0d phase=%0h",
                                 hp, phase, e[HP_W+PH_W-1:PH_W], e[PH_W-1:0]);
                    end
                end
                prev = cur;
            end
            if (sweep_done) sd_cnt++;
            if (dds_rst)    rc_cnt++;
        end
        while (pq.size() > 0) begin
            p = pq.pop_front();
            case (p.kind)
                K_HP:    act = int'(hp);
                K_PH:    act = int'(phase);
                K_RST:   act = int'(dds_rst);
                K_BUSY:  act = int'(busy);
                K_PEND:  act = int'(upd_pending);
                K_DONE:  act = int'(sweep_done);
                K_IDX:   act = int'(step_idx);
                K_SDCNT: act = sd_cnt;
                K_RCCNT: act = rc_cnt;
                default: act = exp_q.size();
            endcase
            checks++;
            if (act != p.val) begin
                errors++;
                $display("FAIL %s: got %0d, want %0d", p.name, act, p.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input int kind, input int val);
        probe_t p;
        p.kind = kind;
        p.val  = val;
        p.name = n;
        pq.push_back(p);
    endtask

    task automatic sb(input int h, input int ph);
        exp_q.push_back({HP_W'(h), PH_W'(ph)});
    endtask

    task automatic pulse_trig();
        harmonic_trig = 1'b1;
        tick();
        harmonic_trig = 1'b0;
        repeat (6) tick();
    endtask

    task automatic start_sweep();
        sw_start = 1'b1;
        tick();
        sw_start = 1'b0;
        tick();
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_hp"}, K_HP, 0);
        chk({n, "_phase"}, K_PH, 0);
        chk({n, "_dds_rst"}, K_RST, 0);
        chk({n, "_busy"}, K_BUSY, 0);
        chk({n, "_pending"}, K_PEND, 0);
        chk({n, "_done"}, K_DONE, 0);
        chk({n, "_idx"}, K_IDX, 0);
    endtask

    int one_shot_hp[6] = '{10, 15, 15, 20, 20, 20};
    int loop_hp[9]     = '{15, 20, 10, 15, 20, 10, 15, 20, 10};

    initial begin
        rst = 1'b1; cfg_hp = '0; cfg_phase = '0; cfg_upd = 1'b0;
        sw_start = 1'b0; sw_abort = 1'b0; sw_loop = 1'b0;
        sw_hp_stop = '0; sw_hp_step = '0; sw_dwell = '0; harmonic_trig = 1'b0;
        repeat (3) tick();
        chk_zero("reset");
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // stalled DDS: applied one edge after pending rises, no trig needed
        sb(50, 0);
        cfg_hp = 14'd50; cfg_upd = 1'b1; tick(); cfg_upd = 1'b0;
        chk("stall_pending", K_PEND, 1);
        tick();
        chk("stall_hp", K_HP, 50);
        chk("stall_pending_clr", K_PEND, 0);

        // strobe coincident with a boundary: applied at once
        sb(100, 0);
        cfg_hp = 14'd100; cfg_upd = 1'b1; harmonic_trig = 1'b1; tick();
        cfg_upd = 1'b0; harmonic_trig = 1'b0;
        chk("same_cycle_hp", K_HP, 100);
        chk("same_cycle_pending", K_PEND, 0);

        // mid-period update waits for the next boundary
        cfg_hp = 14'd200; cfg_phase = 12'h400; cfg_upd = 1'b1; tick(); cfg_upd = 1'b0;
        chk("mid_pending", K_PEND, 1);
        repeat (3) tick();
        chk("mid_hold_hp", K_HP, 100);
        sb(200, 'h400);
        harmonic_trig = 1'b1; tick(); harmonic_trig = 1'b0;
        chk("mid_hp", K_HP, 200);
        chk("mid_phase", K_PH, 'h400);
        chk("mid_pending_clr", K_PEND, 0);

        // one-shot sweep 10..20 step 5, dwell 2
        cfg_hp = 14'd10; sw_hp_step = 14'd5; sw_hp_stop = 14'd20; sw_dwell = 16'd2; sw_loop = 1'b0;
        sb(10, 'h400); sb(15, 'h400); sb(20, 'h400);
        sw_start = 1'b1; tick(); sw_start = 1'b0;
        chk("arm_dds_rst", K_RST, 1);
        chk("arm_busy", K_BUSY, 1);
        tick();
        erc++;
        for (int k = 0; k < 6; k++) begin
            pulse_trig();
            chk($sformatf("oneshot_hp_%0d", k), K_HP, one_shot_hp[k]);
        end
        esd++;
        chk("oneshot_done_cnt", K_SDCNT, esd);
        chk("oneshot_rst_cnt", K_RCCNT, erc);
        chk("oneshot_idx", K_IDX, 2);
        chk("oneshot_busy", K_BUSY, 0);

        // looping sweep over 9 dwells
        sw_loop = 1'b1;
        sb(10, 'h400);
        for (int d = 0; d < 9; d++) sb(loop_hp[d], 'h400);
        start_sweep();
        erc++;
        for (int d = 0; d < 9; d++) begin
            pulse_trig();
            pulse_trig();
            chk($sformatf("loop_hp_%0d", d), K_HP, loop_hp[d]);
        end
        chk("loop_done_cnt", K_SDCNT, esd);
        chk("loop_rst_cnt", K_RCCNT, erc);
        chk("loop_busy", K_BUSY, 1);

        // abort while dwelling at 15
        sb(15, 'h400);
        pulse_trig();
        pulse_trig();
        chk("abort_pre_hp", K_HP, 15);
        sw_abort = 1'b1; tick(); sw_abort = 1'b0;
        chk("abort_busy", K_BUSY, 0);
        pulse_trig();
        pulse_trig();
        chk("abort_hold_hp", K_HP, 15);
        chk("abort_done_cnt", K_SDCNT, esd);

        // abort wins over start in IDLE
        sw_start = 1'b1; sw_abort = 1'b1; tick(); sw_start = 1'b0; sw_abort = 1'b0;
        chk("prio_busy", K_BUSY, 0);
        chk("prio_dds_rst", K_RST, 0);
        repeat (2) tick();
        chk("prio_rst_cnt", K_RCCNT, erc);
        chk("prio_hp", K_HP, 15);

        // zero step ends after one dwell
        sw_loop = 1'b0; cfg_hp = 14'd30; sw_hp_step = '0; sw_hp_stop = 14'd100; sw_dwell = 16'd1;
        sb(30, 'h400);
        start_sweep();
        erc++;
        pulse_trig();
        esd++;
        chk("step0_done_cnt", K_SDCNT, esd);
        chk("step0_hp", K_HP, 30);
        chk("step0_busy", K_BUSY, 0);

        // carry out of HP_W bits counts as past stop
        cfg_hp = 14'd16380; sw_hp_step = 14'd10; sw_hp_stop = 14'd16383;
        sb(16380, 'h400);
        start_sweep();
        erc++;
        pulse_trig();
        esd++;
        chk("carry_done_cnt", K_SDCNT, esd);
        chk("carry_hp", K_HP, 16380);
        chk("carry_busy", K_BUSY, 0);

        // dwell 0 behaves as 1
        cfg_hp = 14'd40; sw_hp_step = 14'd4; sw_hp_stop = 14'd44; sw_dwell = '0;
        sb(40, 'h400); sb(44, 'h400);
        start_sweep();
        erc++;
        pulse_trig();
        chk("dwell0_hp1", K_HP, 44);
        chk("dwell0_busy", K_BUSY, 1);
        pulse_trig();
        esd++;
        chk("dwell0_done_cnt", K_SDCNT, esd);
        chk("dwell0_hp2", K_HP, 44);

        // zero start increment finishes within 3 cycles
        cfg_hp = '0;
        sb(0, 'h400);
        sw_start = 1'b1; tick(); sw_start = 1'b0;
        erc++; esd++;
        repeat (2) tick();
        chk("hp0_done_cnt", K_SDCNT, esd);
        chk("hp0_busy", K_BUSY, 0);
        chk("hp0_rst_cnt", K_RCCNT, erc);

        // reset in the middle of a sweep
        cfg_hp = 14'd10; sw_hp_step = 14'd5; sw_hp_stop = 14'd20; sw_dwell = 16'd2;
        sb(10, 'h400);
        start_sweep();
        pulse_trig();
        sb(0, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_zero("midrst");
        tick();
        chk("sb_drained", K_QSZ, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
